// File: rtl/ace_ccu_snoop_arbiter.sv
// ace_ccu_snoop_arbiter
// Round-robin arbiter that shares the single snoop-issue slot among NumInp
// requesters. It registers the granted request toward the snoop interconnect
// and tracks in-flight snoops in a slot table. A request whose line index
// matches an in-flight entry is withheld.
//
// Optional feature: define ACE_CCU_SNOOP_ARB_PERF_EN to build a saturating
// conflict-stall counter on stall_cnt_o. When it is undefined, stall_cnt_o
// is tied to zero.
//
// Output register FSM:
//   state      | meaning
//   OUP_EMPTY  | no request held toward the interconnect
//   OUP_FULL   | request held; oup_* stable until oup_ready_i
module ace_ccu_snoop_arbiter #(
   parameter int unsigned NumInp    = 4,
   parameter int unsigned IdxWidth  = 8,
   parameter int unsigned MaxTrans  = 8,
   parameter int unsigned SelWidth  = $clog2(NumInp),
   parameter int unsigned SlotWidth = $clog2(MaxTrans)
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [NumInp-1:0]          inp_valid_i,
   input  logic [NumInp*IdxWidth-1:0] inp_idx_i,
   output logic [NumInp-1:0]          inp_ready_o,
   output logic                       oup_valid_o,
   input  logic                       oup_ready_i,
   output logic [SelWidth-1:0]        oup_sel_o,
   output logic [IdxWidth-1:0]        oup_idx_o,
   output logic [SlotWidth-1:0]       oup_slot_o,
   input  logic                       done_i,
   input  logic [SlotWidth-1:0]       done_slot_i,
   output logic [31:0]                stall_cnt_o
);

   typedef enum logic {OUP_EMPTY = 1'b0, OUP_FULL = 1'b1} oup_state_e;

   oup_state_e              state_q, state_d;
   logic [MaxTrans-1:0]     slot_vld_q;
   logic [IdxWidth-1:0]     slot_idx_q [MaxTrans];
   logic [SelWidth-1:0]     rr_q;

   logic [IdxWidth-1:0]     req_idx [NumInp];
   logic [NumInp-1:0]       conflict;
   logic [NumInp-1:0]       eligible;
   logic                    any_free;
   logic                    can_load;
   logic [SlotWidth-1:0]    free_slot;
   logic                    gnt_vld;
   logic [SelWidth-1:0]     gnt_sel;
   logic [IdxWidth-1:0]     gnt_idx;

   // Unpack request indices and compare them against every live table entry.
   always_comb begin
      conflict = '0;
      for (int i = 0; i < NumInp; i++) begin
         req_idx[i] = inp_idx_i[i*IdxWidth +: IdxWidth];
         for (int s = 0; s < MaxTrans; s++) begin
            if (slot_vld_q[s] && (slot_idx_q[s] == req_idx[i])) conflict[i] = 1'b1;
         end
      end
   end

   // Lowest free slot; checks use pre-done table state so done_i never feeds inp_ready_o.
   always_comb begin
      any_free  = ~&slot_vld_q;
      free_slot = '0;
      for (int s = MaxTrans-1; s >= 0; s--) begin
         if (!slot_vld_q[s]) free_slot = SlotWidth'(s);
      end
      can_load = (state_q == OUP_EMPTY) || oup_ready_i;
      eligible = inp_valid_i & ~conflict & {NumInp{any_free & can_load}};
   end

   // Round-robin pick: scanning offsets downward leaves the first eligible at or after rr_q.
   always_comb begin
      int unsigned         cand;
      logic [SelWidth-1:0] cand_sel;
      cand     = 0;
      cand_sel = '0;
      gnt_vld  = 1'b0;
      gnt_sel  = '0;
      gnt_idx  = '0;
      for (int j = NumInp-1; j >= 0; j--) begin
         cand = 32'(rr_q) + 32'(j);
         if (cand >= NumInp) cand = cand - NumInp;
         cand_sel = SelWidth'(cand);
         if (eligible[cand_sel]) begin
            gnt_vld = 1'b1;
            gnt_sel = cand_sel;
            gnt_idx = req_idx[cand_sel];
         end
      end
   end

   // Output register FSM state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= OUP_EMPTY;
      else         state_q <= state_d;
   end

   // Output register FSM next state; a grant while FULL and ready issues back-to-back.
   always_comb begin
      state_d = state_q;
      case (state_q)
         OUP_EMPTY: if (gnt_vld) state_d = OUP_FULL;
         OUP_FULL:  if (!gnt_vld && oup_ready_i) state_d = OUP_EMPTY;
         default:   state_d = OUP_EMPTY;
      endcase
   end

   // FSM outputs: registered valid and one-hot combinational grant.
   always_comb begin
      oup_valid_o = (state_q == OUP_FULL);
      inp_ready_o = '0;
      if (gnt_vld) inp_ready_o[gnt_sel] = 1'b1;
   end

   // Output payload, slot table and round-robin pointer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         oup_sel_o  <= '0;
         oup_idx_o  <= '0;
         oup_slot_o <= '0;
         rr_q       <= '0;
         slot_vld_q <= '0;
         for (int s = 0; s < MaxTrans; s++) slot_idx_q[s] <= '0;
      end else begin
         if (done_i) slot_vld_q[done_slot_i] <= 1'b0;
         if (gnt_vld) begin
            oup_sel_o               <= gnt_sel;
            oup_idx_o               <= gnt_idx;
            oup_slot_o              <= free_slot;
            slot_vld_q[free_slot]   <= 1'b1;
            slot_idx_q[free_slot]   <= gnt_idx;
            rr_q <= (gnt_sel == SelWidth'(NumInp-1)) ? '0 : gnt_sel + SelWidth'(1);
         end
      end
   end

`ifdef ACE_CCU_SNOOP_ARB_PERF_EN
   logic [31:0] stall_cnt_q;
   logic        stall_hit;

   // A stall cycle is one where some valid requester is held back purely by an index conflict.
   assign stall_hit = (|(inp_valid_i & conflict)) & any_free & can_load;

   // Saturating conflict-stall counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                               stall_cnt_q <= '0;
      else if (stall_hit && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   assign stall_cnt_o = '0;
`endif

endmodule
